// File: rtl/mic_frame_mixer.sv
`default_nettype none
// ============================================================================
// Module   : mic_frame_mixer
// Purpose  : Sums one sample per mic channel per frame, shifts, saturates and
//            queues the mixed result behind a valid/ready output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module mic_frame_mixer #(
    parameter int NUM_CH     = 4,
    parameter int OUT_W      = 24,
    parameter int SHIFT      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      in_valid,
    input  logic [31:0]               in_sample,
    input  logic [$clog2(NUM_CH)-1:0] in_ch,
    input  logic                      clear,
    output logic [OUT_W-1:0]          out_sample,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      dup_err,
    output logic                      ovf_err,
    output logic                      sat_seen
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int ACC_W  = 32 + CH_W + 1;
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    localparam logic [CH_W:0] NUM_CH_L = NUM_CH[CH_W:0];
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Accumulate stage state
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [NUM_CH-1:0]       ch_mask_q, ch_mask_d;
    logic signed [ACC_W-1:0] hold_q, hold_d;
    logic                    hold_valid_q, hold_valid_d;

    // FIFO and status state
    logic [OUT_W-1:0]        mem_q [FIFO_DEPTH];
    logic [OUT_W-1:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic                    dup_err_q, dup_err_d;
    logic                    ovf_err_q, ovf_err_d;
    logic                    sat_seen_q, sat_seen_d;

    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] sum;
    logic [NUM_CH-1:0]       ch_onehot;
    logic [NUM_CH-1:0]       new_mask;
    logic                    ch_ok;

    assign in_ext    = {{(ACC_W-32){in_sample[31]}}, in_sample};
    assign sum       = acc_q + in_ext;
    assign ch_onehot = NUM_CH'(1) << in_ch;
    assign new_mask  = ch_mask_q | ch_onehot;
    assign ch_ok     = ({1'b0, in_ch} < NUM_CH_L);

    always_comb begin
        acc_d        = acc_q;
        ch_mask_d    = ch_mask_q;
        hold_d       = hold_q;
        hold_valid_d = 1'b0;
        dup_err_d    = dup_err_q;
        if (in_valid) begin
            if (!ch_ok || ((ch_mask_q & ch_onehot) != '0)) begin
                dup_err_d = 1'b1;
            end else if (new_mask == {NUM_CH{1'b1}}) begin
                // Frame complete: hand off and restart so the next frame's
                // first sample can land on the very next cycle.
                hold_d       = sum;
                hold_valid_d = 1'b1;
                acc_d        = '0;
                ch_mask_d    = '0;
            end else begin
                acc_d     = sum;
                ch_mask_d = new_mask;
            end
        end
        if (clear) begin
            acc_d        = '0;
            ch_mask_d    = '0;
            hold_valid_d = 1'b0;
            dup_err_d    = 1'b0;
        end
    end

    // Reduce stage: arithmetic shift then clip into OUT_W signed range
    logic signed [ACC_W-1:0] shifted;
    logic [OUT_W-1:0]        red_val;
    logic                    red_clip;

    assign shifted = hold_q >>> SHIFT;

    always_comb begin
        red_val  = shifted[OUT_W-1:0];
        red_clip = 1'b0;
        if (shifted > OUT_MAX) begin
            red_val  = OUT_MAX[OUT_W-1:0];
            red_clip = 1'b1;
        end else if (shifted < OUT_MIN) begin
            red_val  = OUT_MIN[OUT_W-1:0];
            red_clip = 1'b1;
        end
    end

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push_ok;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                        (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign pop        = !fifo_empty && out_ready;
    assign push_ok    = hold_valid_q && (!fifo_full || pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        ovf_err_d  = ovf_err_q | (hold_valid_q && !push_ok);
        sat_seen_d = sat_seen_q | (hold_valid_q && red_clip);
        if (push_ok) begin
            mem_d[wr_ptr_q[ADDR_W-1:0]] = red_val;
        end
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            ovf_err_d  = 1'b0;
            sat_seen_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            acc_q        <= '0;
            ch_mask_q    <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            dup_err_q    <= 1'b0;
            ovf_err_q    <= 1'b0;
            sat_seen_q   <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            ch_mask_q    <= ch_mask_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            dup_err_q    <= dup_err_d;
            ovf_err_q    <= ovf_err_d;
            sat_seen_q   <= sat_seen_d;
        end
    end

    // Head is forced to zero when empty so stale entries never leak out
    assign out_valid  = !fifo_empty;
    assign out_sample = fifo_empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign dup_err    = dup_err_q;
    assign ovf_err    = ovf_err_q;
    assign sat_seen   = sat_seen_q;

endmodule
`default_nettype wire

// File: tb/tb_mic_frame_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mic_frame_mixer
// Purpose  : Scoreboard bench for mic_frame_mixer with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mic_frame_mixer;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        in_valid;
    logic [31:0] in_sample;
    logic [1:0]  in_ch;
    logic        clear;
    logic [23:0] out_sample;
    logic        out_valid;
    logic        out_ready;
    logic        dup_err;
    logic        ovf_err;
    logic        sat_seen;

    int checks   = 0;
    int failures = 0;
    int n_pop    = 0;
    logic [23:0] sb[$];

    always #5 CLK = ~CLK;

    mic_frame_mixer #(
        .NUM_CH(4), .OUT_W(24), .SHIFT(2), .FIFO_DEPTH(4)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .in_valid(in_valid),
        .in_sample(in_sample), .in_ch(in_ch), .clear(clear),
        .out_sample(out_sample), .out_valid(out_valid), .out_ready(out_ready),
        .dup_err(dup_err), .ovf_err(ovf_err), .sat_seen(sat_seen)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Handshake sampled mid-cycle; the following rising edge consumes it
    initial begin
        forever begin
            @(negedge CLK);
            if (RESET_N && out_valid && out_ready) begin
                n_pop++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %0h expected none", out_sample);
                end else begin
                    chk("out_sample", {40'd0, out_sample}, {40'd0, sb.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [1:0] ch, input logic [31:0] s);
        in_valid  = 1'b1;
        in_ch     = ch;
        in_sample = s;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] s0, input logic [31:0] s1,
                              input logic [31:0] s2, input logic [31:0] s3);
        send(2'd0, s0);
        send(2'd1, s1);
        send(2'd2, s2);
        send(2'd3, s3);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        chk("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    int pop_base;

    initial begin
        RESET_N   = 1'b0;
        in_valid  = 1'b0;
        in_sample = '0;
        in_ch     = '0;
        clear     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_sample", {40'd0, out_sample}, 64'd0);
        chk("rst_flags", {61'd0, dup_err, ovf_err, sat_seen}, 64'd0);
        RESET_N = 1'b1;
        tick();

        // Sum and shift, with latency and single-cycle valid
        sb.push_back(24'd250);
        send_frame(32'd100, 32'd200, 32'd300, 32'd400);
        chk("lat_k_valid", {63'd0, out_valid}, 64'd0);
        tick();
        chk("lat_k1_valid", {63'd0, out_valid}, 64'd1);
        chk("lat_k1_sample", {40'd0, out_sample}, 64'd250);
        tick();
        chk("lat_k2_valid", {63'd0, out_valid}, 64'd0);

        // Saturation both ways
        sb.push_back(24'h7FFFFF);
        send_frame(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
        tick(); tick();
        chk("sat_max_flag", {63'd0, sat_seen}, 64'd1);
        sb.push_back(24'h800000);
        send_frame(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);
        wait_drain(10);
        pulse_clear();
        chk("clear_sat", {63'd0, sat_seen}, 64'd0);

        // Negative sum rounds toward minus infinity
        sb.push_back(24'hFFFFFA);
        send_frame(-32'sd5, -32'sd5, -32'sd5, -32'sd6);
        wait_drain(10);
        chk("neg_no_sat", {63'd0, sat_seen}, 64'd0);

        // Duplicate channel ignored, out-of-order completion
        sb.push_back(24'd4);
        send(2'd2, 32'd10);
        send(2'd2, 32'd99);
        send(2'd0, 32'd1);
        send(2'd3, 32'd2);
        send(2'd1, 32'd3);
        wait_drain(10);
        chk("dup_flag", {63'd0, dup_err}, 64'd1);
        pulse_clear();
        chk("clear_dup", {63'd0, dup_err}, 64'd0);

        // Overflow: five frames with no consumer, fifth dropped
        out_ready = 1'b0;
        for (int f = 1; f <= 5; f++) begin
            if (f <= 4) sb.push_back(24'(4 * f));
            send_frame(32'(4 * f), 32'(4 * f), 32'(4 * f), 32'(4 * f));
        end
        tick(); tick();
        chk("ovf_flag", {63'd0, ovf_err}, 64'd1);
        chk("ovf_full_valid", {63'd0, out_valid}, 64'd1);
        chk("ovf_head", {40'd0, out_sample}, 64'd4);
        pop_base  = n_pop;
        out_ready = 1'b1;
        wait_drain(20);
        tick(); tick();
        chk("ovf_pop_count", 64'(n_pop - pop_base), 64'd4);
        chk("ovf_empty", {63'd0, out_valid}, 64'd0);
        pulse_clear();
        chk("clear_ovf", {63'd0, ovf_err}, 64'd0);

        // Async reset mid-frame
        send(2'd0, 32'd8);
        send(2'd0, 32'd8);
        send(2'd1, 32'd8);
        chk("pre_rst_dup", {63'd0, dup_err}, 64'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_sample", {40'd0, out_sample}, 64'd0);
        chk("async_rst_flags", {61'd0, dup_err, ovf_err, sat_seen}, 64'd0);
        #3;
        RESET_N = 1'b1;
        sb.push_back(24'd8);
        send_frame(32'd8, 32'd8, 32'd8, 32'd8);
        wait_drain(10);
        chk("post_rst_dup", {63'd0, dup_err}, 64'd0);

        // Same again with clear
        send(2'd0, 32'd8);
        send(2'd0, 32'd8);
        send(2'd1, 32'd8);
        chk("pre_clr_dup", {63'd0, dup_err}, 64'd1);
        pulse_clear();
        chk("clr_dup", {63'd0, dup_err}, 64'd0);
        sb.push_back(24'd8);
        send_frame(32'd8, 32'd8, 32'd8, 32'd8);
        wait_drain(10);
        tick(); tick();
        chk("final_empty", {63'd0, out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
